// File: rtl/alu_arbiter.sv
// Two-port arbiter that time-shares one ALU.
// Registered ALU input stage and result/flag return stage give a fixed 2-cycle latency.
module alu_arbiter #(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  cmd0,
  input  logic [3:0]  cmd1,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] b0,
  input  logic [31:0] b1,
  input  logic        cin0,
  input  logic        cin1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] result,
  output logic [3:0]  sr,
  output logic [3:0]  alu_cmd,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic        alu_cin,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_sr
);

  logic        last_q, last_d;
  logic        s1_valid_q, s1_valid_d;
  logic        s1_owner_q, s1_owner_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [31:0] in1_q, in1_d;
  logic [31:0] in2_q, in2_d;
  logic        cin_q, cin_d;
  logic [31:0] res_q, res_d;
  logic [3:0]  sr_q, sr_d;
  logic        rv0_q, rv0_d;
  logic        rv1_q, rv1_d;

  logic pick1;
  logic acc;

  // On conflict: port 1 wins only in round-robin mode when port 0 went last
  assign pick1 = FIXED_PRI ? 1'b0 : ~last_q;

  assign gnt0 = ~rst & ~hold & req0 & (~req1 | ~pick1);
  assign gnt1 = ~rst & ~hold & req1 & (~req0 | pick1);
  assign acc  = gnt0 | gnt1;

  always_comb begin
    last_d     = last_q;
    s1_valid_d = s1_valid_q;
    s1_owner_d = s1_owner_q;
    cmd_d      = cmd_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    cin_d      = cin_q;
    res_d      = res_q;
    sr_d       = sr_q;
    rv0_d      = 1'b0;
    rv1_d      = 1'b0;
    if (!hold) begin
      s1_valid_d = acc;
      if (acc) begin
        s1_owner_d = gnt1;
        last_d     = gnt1;
        cmd_d      = gnt1 ? cmd1 : cmd0;
        in1_d      = gnt1 ? a1 : a0;
        in2_d      = gnt1 ? b1 : b0;
        cin_d      = gnt1 ? cin1 : cin0;
      end
      if (s1_valid_q) begin
        res_d = alu_result;
        sr_d  = alu_sr;
        rv0_d = ~s1_owner_q;
        rv1_d = s1_owner_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= 1'b1;
      s1_valid_q <= 1'b0;
      s1_owner_q <= 1'b0;
      cmd_q      <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      cin_q      <= 1'b0;
      res_q      <= '0;
      sr_q       <= '0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
    end else begin
      last_q     <= last_d;
      s1_valid_q <= s1_valid_d;
      s1_owner_q <= s1_owner_d;
      cmd_q      <= cmd_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      cin_q      <= cin_d;
      res_q      <= res_d;
      sr_q       <= sr_d;
      rv0_q      <= rv0_d;
      rv1_q      <= rv1_d;
    end
  end

  assign alu_cmd = cmd_q;
  assign alu_in1 = in1_q;
  assign alu_in2 = in2_q;
  assign alu_cin = cin_q;
  assign result  = res_q;
  assign sr      = sr_q;
  assign rvalid0 = rv0_q;
  assign rvalid1 = rv1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU stub.
// Round-robin instance is fully checked; a fixed-priority instance is grant-checked.
module tb_alu_arbiter;

  localparam logic [3:0] MOV = 4'd1;
  localparam logic [3:0] ADD = 4'd2;
  localparam logic [3:0] ADC = 4'd3;
  localparam logic [3:0] SUB = 4'd4;
  localparam logic [3:0] SBC = 4'd5;
  localparam logic [3:0] AND = 4'd6;
  localparam logic [3:0] ORR = 4'd7;
  localparam logic [3:0] EOR = 4'd8;

  typedef struct {
    bit          port;
    logic [31:0] res;
    logic [3:0]  sr;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  logic rst, hold, req0, req1, cin0, cin1;
  logic [3:0]  cmd0, cmd1;
  logic [31:0] a0, a1, b0, b1;

  logic        gnt0, gnt1, rvalid0, rvalid1, alu_cin;
  logic [31:0] result, alu_in1, alu_in2, alu_result;
  logic [3:0]  sr, alu_cmd, alu_sr;

  logic        f_gnt0, f_gnt1, f_rv0, f_rv1, f_cin;
  logic [31:0] f_res, f_in1, f_in2, f_alu_res;
  logic [3:0]  f_sr, f_cmd, f_alu_sr;

  always #5 clk = ~clk;

  function automatic logic [35:0] alu_f(
    input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
    input logic ci);
    logic [32:0] w;
    logic [31:0] r;
    logic cy, v;
    w = '0; r = '0; cy = 1'b0; v = 1'b0;
    case (c)
      MOV: r = b;
      ADD, ADC: begin
        w  = {1'b0, a} + {1'b0, b} + {32'b0, (c == ADC) & ci};
        r  = w[31:0];
        cy = w[32];
        v  = (a[31] == b[31]) && (r[31] != a[31]);
      end
      SUB, SBC: begin
        w  = {1'b0, a} - {1'b0, b} - {32'b0, (c == SBC) & ~ci};
        r  = w[31:0];
        cy = ~w[32];
        v  = (a[31] != b[31]) && (r[31] != a[31]);
      end
      AND: r = a & b;
      ORR: r = a | b;
      EOR: r = a ^ b;
      default: r = '0;
    endcase
    return {r == 32'd0, cy, r[31], v, r};
  endfunction

  always_comb {alu_sr, alu_result} = alu_f(alu_cmd, alu_in1, alu_in2, alu_cin);
  always_comb {f_alu_sr, f_alu_res} = alu_f(f_cmd, f_in1, f_in2, f_cin);

  alu_arbiter #(.FIXED_PRI(1'b0)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .cin0(cin0), .cin1(cin1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .result(result), .sr(sr), .alu_cmd(alu_cmd), .alu_in1(alu_in1),
    .alu_in2(alu_in2), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_sr(alu_sr)
  );

  alu_arbiter #(.FIXED_PRI(1'b1)) dut_fp (
    .clk(clk), .rst(rst), .hold(hold),
    .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .cin0(cin0), .cin1(cin1),
    .gnt0(f_gnt0), .gnt1(f_gnt1), .rvalid0(f_rv0), .rvalid1(f_rv1),
    .result(f_res), .sr(f_sr), .alu_cmd(f_cmd), .alu_in1(f_in1),
    .alu_in2(f_in2), .alu_cin(f_cin),
    .alu_result(f_alu_res), .alu_sr(f_alu_sr)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit p, input logic [31:0] r,
                      input logic [3:0] s);
    exp_t e;
    e.port = p; e.res = r; e.sr = s;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: pops one expectation per rvalid pulse
  always @(negedge clk) begin
    if (!rst && (rvalid0 || rvalid1)) begin
      exp_t e;
      check("one_rvalid", {62'b0, rvalid0, rvalid1}, {62'b0, !rvalid1, !rvalid0});
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rvalid: got rv0=%0b rv1=%0b, expected none",
                 rvalid0, rvalid1);
      end else begin
        e = sb.pop_front();
        check("rv_port", {63'b0, rvalid1}, {63'b0, e.port});
        check("result", {32'b0, result}, {32'b0, e.res});
        check("sr", {60'b0, sr}, {60'b0, e.sr});
      end
    end
  end

  initial begin
    rst = 1'b1; hold = 1'b0; req0 = 1'b0; req1 = 1'b0;
    cmd0 = '0; cmd1 = '0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    cin0 = 1'b0; cin1 = 1'b0;
    #1;
    req0 = 1'b1;
    #1;
    check("gnt0_in_rst", {63'b0, gnt0}, 64'd0);
    req0 = 1'b0;
    tick();
    tick();
    check("rst_rvalid", {62'b0, rvalid0, rvalid1}, 64'd0);
    check("rst_result", {28'b0, sr, result}, 64'd0);
    check("rst_alu", {alu_cmd, alu_cin, alu_in1[26:0], alu_in2}, 64'd0);
    rst = 1'b0;
    tick();

    // 1: single ADD on port 0, latency check
    req0 = 1'b1; cmd0 = ADD; a0 = 32'd5; b0 = 32'd7;
    #1;
    check("t1_gnt0", {62'b0, gnt0, gnt1}, 64'd2);
    push(1'b0, 32'd12, 4'b0000);
    tick();
    req0 = 1'b0;
    check("t1_rv_early", {63'b0, rvalid0}, 64'd0);
    tick();
    check("t1_rv_on_time", {63'b0, rvalid0}, 64'd1);
    tick();

    // 2/3: both requesting; RR alternates from port 0, FP always port 0
    do_reset();
    req0 = 1'b1; cmd0 = ADD; a0 = 32'd10; b0 = 32'd20;
    req1 = 1'b1; cmd1 = EOR; a1 = 32'hF0F0; b1 = 32'h0FF0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_rr_gnt", {62'b0, gnt0, gnt1},
            (i % 2 == 0) ? 64'd2 : 64'd1);
      check("t3_fp_gnt", {62'b0, f_gnt0, f_gnt1}, 64'd2);
      if (i % 2 == 0) push(1'b0, 32'd30, 4'b0000);
      else push(1'b1, 32'h0000FF00, 4'b0000);
      tick();
    end
    req0 = 1'b0;
    #1;
    check("t3_fp_gnt1", {62'b0, f_gnt0, f_gnt1}, 64'd1);
    check("t2_rr_gnt1", {62'b0, gnt0, gnt1}, 64'd1);
    push(1'b1, 32'h0000FF00, 4'b0000);
    tick();
    req1 = 1'b0;
    tick();
    tick();
    tick();

    // 4: SUB on port 1 then 3 cycles of hold
    do_reset();
    req1 = 1'b1; cmd1 = SUB; a1 = 32'd3; b1 = 32'd3;
    #1;
    check("t4_gnt1", {62'b0, gnt0, gnt1}, 64'd1);
    push(1'b1, 32'd0, 4'b1100);
    tick();
    req1 = 1'b0; hold = 1'b1; req0 = 1'b1; cmd0 = ORR;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_hold_gnt", {62'b0, gnt0, gnt1}, 64'd0);
      tick();
      check("t4_hold_rv", {62'b0, rvalid0, rvalid1}, 64'd0);
    end
    hold = 1'b0; req0 = 1'b0;
    tick();
    check("t4_after_hold_rv", {62'b0, rvalid0, rvalid1}, 64'd1);
    tick();

    // 5: ADC with carry-in, plus an unused opcode
    req0 = 1'b1; cmd0 = ADC; a0 = 32'd1; b0 = 32'd1; cin0 = 1'b1;
    #1;
    push(1'b0, 32'd3, 4'b0000);
    tick();
    check("t5_alu_cin", {59'b0, alu_cmd, alu_cin}, {59'b0, ADC, 1'b1});
    cmd0 = 4'b1100; cin0 = 1'b0; a0 = 32'd9; b0 = 32'd4;
    push(1'b0, 32'd0, 4'b1000);
    tick();
    check("t5_unused_fwd", {60'b0, alu_cmd}, 64'hC);
    req0 = 1'b0;
    tick();
    tick();

    // 6: accept then reset -> op discarded, last back to 1
    req0 = 1'b1; cmd0 = MOV; a0 = 32'd0; b0 = 32'h55;
    tick();
    rst = 1'b1;
    #1;
    check("t6_gnt_rst", {62'b0, gnt0, gnt1}, 64'd0);
    tick();
    check("t6_rv", {62'b0, rvalid0, rvalid1}, 64'd0);
    check("t6_res", {28'b0, sr, result}, 64'd0);
    check("t6_alu", {alu_cmd, alu_cin, alu_in1[26:0], alu_in2}, 64'd0);
    rst = 1'b0; req0 = 1'b0;
    tick();
    tick();
    req0 = 1'b1; req1 = 1'b1;
    #1;
    check("t6_last1", {62'b0, gnt0, gnt1}, 64'd2);
    req0 = 1'b0; req1 = 1'b0;

    for (int i = 0; i < 6; i++) tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
